// File: rtl/risc_spm_pkg.sv
// Shared definitions for the RISC_SPM processor: data width, control-unit
// state encoding, opcodes and bus-select encodings. The ALU and datapath
// reuse the opcode and select constants from here.
package risc_spm_pkg;

  localparam int WORD = 8;
  localparam int SW   = 4;

  // Control-unit states; encodings are visible on state_dbg.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FET1 = 4'd1,
    S_FET2 = 4'd2,
    S_DEC  = 4'd3,
    S_EX1  = 4'd4,
    S_RD1  = 4'd5,
    S_RD2  = 4'd6,
    S_WR1  = 4'd7,
    S_WR2  = 4'd8,
    S_BR1  = 4'd9,
    S_BR2  = 4'd10,
    S_HALT = 4'd11
  } state_t;

  // Opcodes held in instruction[7:4]; 9..E are illegal.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4;
  localparam logic [3:0] OP_RD  = 4'h5;
  localparam logic [3:0] OP_WR  = 4'h6;
  localparam logic [3:0] OP_BR  = 4'h7;
  localparam logic [3:0] OP_BRZ = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Bus_1 source selects.
  localparam logic [2:0] SEL1_R0 = 3'd0;
  localparam logic [2:0] SEL1_R1 = 3'd1;
  localparam logic [2:0] SEL1_R2 = 3'd2;
  localparam logic [2:0] SEL1_R3 = 3'd3;
  localparam logic [2:0] SEL1_PC = 3'd4;

  // Bus_2 source selects.
  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

  // One-hot register-file load enable for register index idx.
  function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Bus_1 select that drives register idx onto the bus.
  function automatic logic [2:0] reg_sel(input logic [1:0] idx);
    return {1'b0, idx};
  endfunction

endpackage

// File: rtl/control_decode.sv
// Purely combinational part of the RISC_SPM control unit: decodes the
// current state, instruction and zero flag into datapath strobes, the next
// state and a request to raise the sticky error flag.
module control_decode
  import risc_spm_pkg::*;
#(
  parameter int WORD = risc_spm_pkg::WORD
) (
  input  state_t            state,
  input  logic [WORD-1:0]   instruction,
  input  logic              zero,
  output logic [3:0]        load_r,
  output logic              load_pc,
  output logic              inc_pc,
  output logic [2:0]        sel_bus_1,
  output logic [1:0]        sel_bus_2,
  output logic              load_ir,
  output logic              load_add_r,
  output logic              load_reg_y,
  output logic              load_reg_z,
  output logic              write,
  output state_t            next_state,
  output logic              set_err
);

  logic [3:0] opcode_s;
  logic [1:0] src_s;
  logic [1:0] dest_s;

  assign opcode_s = instruction[7:4];
  assign src_s    = instruction[3:2];
  assign dest_s   = instruction[1:0];

  // Output and next-state decode; every output defaults to 0 each state.
  always_comb begin
    load_r     = 4'b0000;
    load_pc    = 1'b0;
    inc_pc     = 1'b0;
    sel_bus_1  = SEL1_R0;
    sel_bus_2  = SEL2_ALU;
    load_ir    = 1'b0;
    load_add_r = 1'b0;
    load_reg_y = 1'b0;
    load_reg_z = 1'b0;
    write      = 1'b0;
    next_state = S_HALT;
    set_err    = 1'b0;

    case (state)
      S_IDLE: begin
        next_state = S_FET1;
      end

      S_FET1: begin
        sel_bus_1  = SEL1_PC;
        sel_bus_2  = SEL2_BUS1;
        load_add_r = 1'b1;
        next_state = S_FET2;
      end

      S_FET2: begin
        sel_bus_2  = SEL2_MEM;
        load_ir    = 1'b1;
        inc_pc     = 1'b1;
        next_state = S_DEC;
      end

      S_DEC: begin
        case (opcode_s)
          OP_NOP: begin
            next_state = S_FET1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            sel_bus_1  = reg_sel(src_s);
            load_reg_y = 1'b1;
            next_state = S_EX1;
          end
          OP_NOT: begin
            sel_bus_1  = reg_sel(src_s);
            sel_bus_2  = SEL2_ALU;
            load_reg_z = 1'b1;
            load_r     = reg_onehot(dest_s);
            next_state = S_FET1;
          end
          OP_RD: begin
            sel_bus_1  = SEL1_PC;
            sel_bus_2  = SEL2_BUS1;
            load_add_r = 1'b1;
            next_state = S_RD1;
          end
          OP_WR: begin
            sel_bus_1  = SEL1_PC;
            sel_bus_2  = SEL2_BUS1;
            load_add_r = 1'b1;
            next_state = S_WR1;
          end
          OP_BR: begin
            sel_bus_1  = SEL1_PC;
            sel_bus_2  = SEL2_BUS1;
            load_add_r = 1'b1;
            next_state = S_BR1;
          end
          OP_BRZ: begin
            if (zero) begin
              sel_bus_1  = SEL1_PC;
              sel_bus_2  = SEL2_BUS1;
              load_add_r = 1'b1;
              next_state = S_BR1;
            end else begin
              // Not taken: step the PC over the branch-address byte.
              inc_pc     = 1'b1;
              next_state = S_FET1;
            end
          end
          OP_HLT: begin
            next_state = S_HALT;
          end
          default: begin
            next_state = S_HALT;
            set_err    = 1'b1;
          end
        endcase
      end

      S_EX1: begin
        sel_bus_1  = reg_sel(dest_s);
        sel_bus_2  = SEL2_ALU;
        load_reg_z = 1'b1;
        load_r     = reg_onehot(dest_s);
        next_state = S_FET1;
      end

      S_RD1: begin
        sel_bus_2  = SEL2_MEM;
        load_add_r = 1'b1;
        inc_pc     = 1'b1;
        next_state = S_RD2;
      end

      S_RD2: begin
        sel_bus_2  = SEL2_MEM;
        load_r     = reg_onehot(dest_s);
        next_state = S_FET1;
      end

      S_WR1: begin
        sel_bus_2  = SEL2_MEM;
        load_add_r = 1'b1;
        inc_pc     = 1'b1;
        next_state = S_WR2;
      end

      S_WR2: begin
        sel_bus_1  = reg_sel(src_s);
        write      = 1'b1;
        next_state = S_FET1;
      end

      S_BR1: begin
        sel_bus_2  = SEL2_MEM;
        load_add_r = 1'b1;
        next_state = S_BR2;
      end

      S_BR2: begin
        sel_bus_2  = SEL2_MEM;
        load_pc    = 1'b1;
        next_state = S_FET1;
      end

      S_HALT: begin
        next_state = S_HALT;
      end

      default: begin
        // Encodings 12..15 are unreachable; treat them as a fault.
        next_state = S_HALT;
        set_err    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// RISC_SPM instruction-sequencing control unit. Holds the state register and
// the sticky illegal-opcode flag; all strobes are decoded combinationally
// from the state so that an asynchronous reset drops them immediately.
module control_unit
  import risc_spm_pkg::*;
#(
  parameter int WORD = risc_spm_pkg::WORD,
  parameter int SW   = risc_spm_pkg::SW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD-1:0]   instruction,
  input  logic              zero,
  output logic [3:0]        load_r,
  output logic              load_pc,
  output logic              inc_pc,
  output logic [2:0]        sel_bus_1,
  output logic [1:0]        sel_bus_2,
  output logic              load_ir,
  output logic              load_add_r,
  output logic              load_reg_y,
  output logic              load_reg_z,
  output logic              write,
  output logic              err_flag,
  output logic [SW-1:0]     state_dbg
);

  state_t state_r;
  state_t next_state_s;
  logic   set_err_s;
  logic   err_flag_r;

  control_decode #(
    .WORD (WORD)
  ) u_decode (
    .state       (state_r),
    .instruction (instruction),
    .zero        (zero),
    .load_r      (load_r),
    .load_pc     (load_pc),
    .inc_pc      (inc_pc),
    .sel_bus_1   (sel_bus_1),
    .sel_bus_2   (sel_bus_2),
    .load_ir     (load_ir),
    .load_add_r  (load_add_r),
    .load_reg_y  (load_reg_y),
    .load_reg_z  (load_reg_z),
    .write       (write),
    .next_state  (next_state_s),
    .set_err     (set_err_s)
  );

  // State register and sticky error flag; only reset clears the flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      err_flag_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (set_err_s) begin
        err_flag_r <= 1'b1;
      end else begin
        err_flag_r <= err_flag_r;
      end
    end
  end

  assign err_flag  = err_flag_r;
  assign state_dbg = SW'(state_r);

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit. Each table row is one clock
// cycle of a continuous instruction stream with hand-computed expectations.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [7:0] instruction;
  logic       zero;
  logic [3:0] load_r;
  logic       load_pc;
  logic       inc_pc;
  logic [2:0] sel_bus_1;
  logic [1:0] sel_bus_2;
  logic       load_ir;
  logic       load_add_r;
  logic       load_reg_y;
  logic       load_reg_z;
  logic       write;
  logic       err_flag;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // strobe vector: {load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write}
  localparam logic [6:0] NO  = 7'b0000000;
  localparam logic [6:0] LPC = 7'b1000000;
  localparam logic [6:0] INC = 7'b0100000;
  localparam logic [6:0] IR  = 7'b0010000;
  localparam logic [6:0] AR  = 7'b0001000;
  localparam logic [6:0] RY  = 7'b0000100;
  localparam logic [6:0] RZ  = 7'b0000010;
  localparam logic [6:0] WR  = 7'b0000001;

  logic [6:0] strobes;
  assign strobes = {load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write};

  typedef struct {
    logic [7:0] instr;
    logic       z;
    logic [3:0] st;
    logic [3:0] lr;
    logic [2:0] s1;
    logic [1:0] s2;
    logic [6:0] sb;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .zero        (zero),
    .load_r      (load_r),
    .load_pc     (load_pc),
    .inc_pc      (inc_pc),
    .sel_bus_1   (sel_bus_1),
    .sel_bus_2   (sel_bus_2),
    .load_ir     (load_ir),
    .load_add_r  (load_add_r),
    .load_reg_y  (load_reg_y),
    .load_reg_z  (load_reg_z),
    .write       (write),
    .err_flag    (err_flag),
    .state_dbg   (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] i, input logic z, input logic [3:0] st, input logic [3:0] lr,
                     input logic [2:0] s1, input logic [1:0] s2, input logic [6:0] sb, input logic e);
    vec_t v;
    v.instr = i; v.z = z; v.st = st; v.lr = lr; v.s1 = s1; v.s2 = s2; v.sb = sb; v.err = e;
    vecs.push_back(v);
  endtask

  // Compare every output against one expectation row.
  task automatic chk_all(input string tag, input int idx, input vec_t v);
    chk({tag, ".state"}, idx, 32'(state_dbg), 32'(v.st));
    chk({tag, ".load_r"}, idx, 32'(load_r), 32'(v.lr));
    chk({tag, ".sel_bus_1"}, idx, 32'(sel_bus_1), 32'(v.s1));
    chk({tag, ".sel_bus_2"}, idx, 32'(sel_bus_2), 32'(v.s2));
    chk({tag, ".strobes"}, idx, 32'(strobes), 32'(v.sb));
    chk({tag, ".err_flag"}, idx, 32'(err_flag), 32'(v.err));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Fetch expectations shared by every instruction.
  task automatic add_fetch(input logic [7:0] i, input logic z);
    add(i, z, 4'd1, 4'b0000, 3'd4, 2'd1, AR, 1'b0);
    add(i, z, 4'd2, 4'b0000, 3'd0, 2'd2, IR | INC, 1'b0);
  endtask

  vec_t v;
  vec_t zero_v;
  logic write_seen;

  initial begin
    rst = 1'b0;
    instruction = 8'h00;
    zero = 1'b0;

    // Build the table: NOP, ADD, SUB, RD, BRZ(nt), BRZ(t), NOT, WR, BR, HLT.
    add(8'h00, 1'b0, 4'd0, 4'b0000, 3'd0, 2'd0, NO, 1'b0);
    add_fetch(8'h00, 1'b0);
    add(8'h00, 1'b0, 4'd3, 4'b0000, 3'd0, 2'd0, NO, 1'b0);
    add_fetch(8'h16, 1'b0);
    add(8'h16, 1'b0, 4'd3, 4'b0000, 3'd1, 2'd0, RY, 1'b0);
    add(8'h16, 1'b0, 4'd4, 4'b0100, 3'd2, 2'd0, RZ, 1'b0);
    add_fetch(8'h27, 1'b0);
    add(8'h27, 1'b0, 4'd3, 4'b0000, 3'd1, 2'd0, RY, 1'b0);
    add(8'h27, 1'b0, 4'd4, 4'b1000, 3'd3, 2'd0, RZ, 1'b0);
    add_fetch(8'h53, 1'b0);
    add(8'h53, 1'b0, 4'd3, 4'b0000, 3'd4, 2'd1, AR, 1'b0);
    add(8'h53, 1'b0, 4'd5, 4'b0000, 3'd0, 2'd2, AR | INC, 1'b0);
    add(8'h53, 1'b0, 4'd6, 4'b1000, 3'd0, 2'd2, NO, 1'b0);
    add_fetch(8'h80, 1'b0);
    add(8'h80, 1'b0, 4'd3, 4'b0000, 3'd0, 2'd0, INC, 1'b0);
    add_fetch(8'h80, 1'b1);
    add(8'h80, 1'b1, 4'd3, 4'b0000, 3'd4, 2'd1, AR, 1'b0);
    add(8'h80, 1'b1, 4'd9, 4'b0000, 3'd0, 2'd2, AR, 1'b0);
    add(8'h80, 1'b1, 4'd10, 4'b0000, 3'd0, 2'd2, LPC, 1'b0);
    add_fetch(8'h4D, 1'b0);
    add(8'h4D, 1'b0, 4'd3, 4'b0010, 3'd3, 2'd0, RZ, 1'b0);
    add_fetch(8'h6E, 1'b0);
    add(8'h6E, 1'b0, 4'd3, 4'b0000, 3'd4, 2'd1, AR, 1'b0);
    add(8'h6E, 1'b0, 4'd7, 4'b0000, 3'd0, 2'd2, AR | INC, 1'b0);
    add(8'h6E, 1'b0, 4'd8, 4'b0000, 3'd3, 2'd0, WR, 1'b0);
    add_fetch(8'h70, 1'b0);
    add(8'h70, 1'b0, 4'd3, 4'b0000, 3'd4, 2'd1, AR, 1'b0);
    add(8'h70, 1'b0, 4'd9, 4'b0000, 3'd0, 2'd2, AR, 1'b0);
    add(8'h70, 1'b0, 4'd10, 4'b0000, 3'd0, 2'd2, LPC, 1'b0);
    add_fetch(8'hF0, 1'b0);
    add(8'hF0, 1'b0, 4'd3, 4'b0000, 3'd0, 2'd0, NO, 1'b0);
    add(8'hF0, 1'b0, 4'd11, 4'b0000, 3'd0, 2'd0, NO, 1'b0);
    add(8'h90, 1'b1, 4'd11, 4'b0000, 3'd0, 2'd0, NO, 1'b0);
    add(8'h90, 1'b1, 4'd11, 4'b0000, 3'd0, 2'd0, NO, 1'b0);

    zero_v.instr = 8'h00; zero_v.z = 1'b0; zero_v.st = 4'd0; zero_v.lr = 4'b0000;
    zero_v.s1 = 3'd0; zero_v.s2 = 2'd0; zero_v.sb = NO; zero_v.err = 1'b0;

    // Reset state while rst is held low.
    #2;
    chk_all("reset", 0, zero_v);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Table walk: one row per clock, inputs driven after the edge, outputs sampled on negedge.
    for (int i = 0; i < vecs.size(); i++) begin
      instruction = vecs[i].instr;
      zero = vecs[i].z;
      @(negedge clk);
      chk_all("table", i, vecs[i]);
      @(posedge clk);
      #1;
    end

    // Illegal opcode: HALT with sticky err_flag held for 20 cycles.
    do_reset();
    instruction = 8'h90;
    zero = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("illegal.pre_state", k, 32'(state_dbg), 32'(k));
      chk("illegal.pre_err", k, 32'(err_flag), 32'd0);
      @(posedge clk);
      #1;
    end
    v = zero_v;
    v.st = 4'd11;
    v.err = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk_all("illegal.halt", k, v);
    end

    // Reset mid-WR1: outputs must clear without a clock edge and no write appears.
    do_reset();
    instruction = 8'h6E;
    write_seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      write_seen = write_seen | write;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("wr1.reached", 0, 32'(state_dbg), 32'd7);
    write_seen = write_seen | write;
    #2;
    rst = 1'b0;
    #1;
    chk_all("wr1.async_reset", 0, zero_v);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      write_seen = write_seen | write;
    end
    chk("wr1.state_held", 0, 32'(state_dbg), 32'd0);
    chk("wr1.no_write", 0, 32'(write_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
